// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared definitions for the async-FIFO write-side controller: FSM state
// encodings and skid-buffer geometry.
package fifo_wr_ctrl_pkg;

    // Write-controller FSM state encodings (also exported on the state port).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PKT   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Skid buffer depth and the derived pointer / occupancy widths.
    localparam int SKID_DEPTH = 2;
    localparam int SKID_AW    = $clog2(SKID_DEPTH);
    localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);
    localparam logic [SKID_CW-1:0] SKID_FULL = SKID_CW'(SKID_DEPTH);

    // True in the states where beats may be accepted and written.
    function automatic logic st_accepts(input logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_PKT);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular skid buffer. Push when in_valid && in_ready, pop when
// out_valid && out_ready; both may happen in the same cycle. clr empties the
// buffer synchronously and wins over a simultaneous push or pop.
module fifo_skid_buf
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SKID_CW-1:0] count_nxt
);

    logic [WIDTH-1:0]   mem [SKID_DEPTH];
    logic [SKID_AW-1:0] wr_ptr;
    logic [SKID_AW-1:0] rd_ptr;
    logic [SKID_CW-1:0] count;
    logic               push;
    logic               pop;

    assign in_ready  = (count < SKID_FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy after this edge, also used by the parent to register its ready.
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Storage array; contents are only meaningful while counted as occupied.
    always_ff @(posedge wclk) begin
        if (push && !clr) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: buffers upstream beats, gates
// packet starts on near_full, never writes while full, handles flush and
// keeps saturating write / overflow counters.
//
// Upstream handshake: a beat transfers on a rising wclk edge where
// s_valid && s_ready; s_ready is registered and only promises room for one
// more beat. The upstream must hold s_valid/s_data/s_last stable until the
// transfer happens.
module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int CNTW  = 16
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             full,
    input  logic             near_full,
    input  logic             over_flow,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    input  logic             flush_req,
    output logic             wptr_clr,
    output logic             flush_ack,
    output logic [CNTW-1:0]  wr_cnt,
    output logic [7:0]       ovf_cnt,
    output logic [1:0]       state
);

    if (ASIZE < 2) begin : g_asize_check
        $error("fifo_wr_ctrl: ASIZE must be at least 2");
    end

    logic [DSIZE:0]     head_data;
    logic               head_valid;
    logic               head_last;
    logic               gate_ok;
    logic               s_accept;
    logic               skid_in_ready;
    logic               skid_clr;
    logic [SKID_CW-1:0] skid_cnt_nxt;
    logic [1:0]         state_nxt;

    assign s_accept  = s_valid && s_ready && skid_in_ready;
    assign skid_clr  = (state == ST_FLUSH);
    assign wdata     = head_data[DSIZE-1:0];
    assign head_last = head_data[DSIZE];

    fifo_skid_buf #(
        .WIDTH(DSIZE + 1)
    ) u_skid (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .clr       (skid_clr),
        .in_valid  (s_accept),
        .in_ready  (skid_in_ready),
        .in_data   ({s_last, s_data}),
        .out_valid (head_valid),
        .out_ready (winc),
        .out_data  (head_data),
        .count_nxt (skid_cnt_nxt)
    );

    // Write strobe: new packets wait for !near_full, in-flight ones only for
    // !full; a flush request in the same cycle suppresses the write.
    always_comb begin
        gate_ok = (state == ST_PKT) || !near_full;
        winc    = head_valid && !full && gate_ok && st_accepts(state) && !flush_req;
    end

    // Next state: FLUSH always lasts one cycle, flush_req beats any write.
    always_comb begin
        state_nxt = state;
        if (state == ST_FLUSH) begin
            state_nxt = ST_DONE;
        end else if (flush_req) begin
            state_nxt = ST_FLUSH;
        end else if (state == ST_DONE) begin
            state_nxt = ST_IDLE;
        end else if (winc) begin
            state_nxt = head_last ? ST_IDLE : ST_PKT;
        end
    end

    // State, registered ready and the one-cycle flush pulses.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= ST_IDLE;
            s_ready   <= 1'b0;
            wptr_clr  <= 1'b0;
            flush_ack <= 1'b0;
        end else begin
            state     <= state_nxt;
            s_ready   <= (skid_cnt_nxt < SKID_FULL) && st_accepts(state_nxt);
            wptr_clr  <= (state_nxt == ST_FLUSH);
            flush_ack <= (state_nxt == ST_DONE);
        end
    end

    // Saturating write and overflow counters, cleared while flushing.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_cnt  <= '0;
            ovf_cnt <= '0;
        end else if (state == ST_FLUSH) begin
            wr_cnt  <= '0;
            ovf_cnt <= '0;
        end else begin
            if (winc && (wr_cnt != '1))        wr_cnt  <= wr_cnt + 1'b1;
            if (over_flow && (ovf_cnt != '1))  ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 8: write data width.
REQ-002 SHALL have parameter ASIZE, default 4: FIFO address width, depth 2**ASIZE; minimum 2.
REQ-003 SHALL have parameter CNTW, default 16: write-count width.
REQ-004 SHALL have port wclk  in  1  write clock, all logic on rising edge.
REQ-005 SHALL have port wrst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_valid  in  1  upstream beat valid.
REQ-007 SHALL have port s_data  in  DSIZE  upstream beat data.
REQ-008 SHALL have port s_last  in  1  final beat of packet.
REQ-009 SHALL have port s_ready  out  1  upstream accept, registered.
REQ-010 SHALL have port full  in  1  registered full flag from the write-pointer block.
REQ-011 SHALL have port near_full  in  1  registered near-full flag.
REQ-012 SHALL have port over_flow  in  1  one-cycle overflow pulse.
REQ-013 SHALL have port winc  out  1  FIFO write strobe.
REQ-014 SHALL have port wdata  out  DSIZE  FIFO write data.
REQ-015 SHALL have port flush_req  in  1  flush request, level or pulse.
REQ-016 SHALL have port wptr_clr  out  1  write-pointer clear, one-cycle pulse.
REQ-017 SHALL have port flush_ack  out  1  flush complete, one-cycle pulse.
REQ-018 SHALL have port wr_cnt  out  CNTW  saturating accepted-write count.
REQ-019 SHALL have port ovf_cnt  out  8  saturating overflow-event count.
REQ-020 SHALL have port state  out  2  current FSM state.

Function
REQ-021 SHALL buffer upstream beats {s_last,s_data} in a 2-entry skid buffer; a transfer occurs when s_valid && s_ready.
REQ-022 SHALL drive s_ready = 1 in the next cycle iff the skid buffer will hold at most one entry and the next state is IDLE or PKT.
REQ-023 SHALL drive winc = head_valid && !full && gate_ok && state in {IDLE,PKT}, combinationally, with wdata = head data.
REQ-024 gate_ok SHALL be 1 in PKT, and in IDLE SHALL be !near_full; new packets never start while near_full=1, but an in-flight packet continues until full.
REQ-025 A write and an upstream accept in the same cycle SHALL both take effect; ordering SHALL be preserved with zero data loss or duplication.
REQ-026 SHALL implement an FSM with IDLE=0, PKT=1, FLUSH=2, DONE=3.
REQ-027 IDLE->PKT on a write with head last=0; PKT->IDLE on a write with head last=1; a single-beat packet (last=1) SHALL remain in IDLE.
REQ-028 SHALL go from any state to FLUSH on flush_req=1; flush_req SHALL take priority over a simultaneous write, and winc SHALL be 0 in that cycle.
REQ-029 In FLUSH: wptr_clr=1 for exactly one cycle, skid buffer emptied, s_ready=0, winc=0; next state DONE.
REQ-030 In DONE: flush_ack=1 for one cycle, s_ready=0; next state IDLE, or FLUSH again if flush_req=1.
REQ-031 wr_cnt SHALL increment on each winc and saturate at 2**CNTW-1.
REQ-032 ovf_cnt SHALL increment on each over_flow pulse and saturate at 255.
REQ-033 Both counters SHALL clear in FLUSH; an over_flow during FLUSH SHALL not be counted.
REQ-034 winc SHALL never be 1 while full=1, so over_flow is never caused by this block.

Reset
REQ-035 On wrst_n=0 asynchronously: state=IDLE, skid buffer empty, s_ready=0, wptr_clr=0, flush_ack=0, wr_cnt=0, ovf_cnt=0; winc=0 follows.
REQ-036 s_ready SHALL rise on the first clock edge after wrst_n deasserts.
REQ-037 A reset mid-packet SHALL discard buffered beats with no winc during or after reset.

Structure
REQ-038 The FSM state encodings and the 2-entry skid depth SHALL be defined in the shared async-FIFO package.
REQ-039 The skid buffer SHALL be a sub-module fifo_skid_buf (params WIDTH; valid/ready in and out; clr input).

Verification
REQ-040 Stream of 20 beats, 1 packet, no reads, ASIZE=4 -> exactly 16 winc, winc=0 while full=1, s_ready=0 once the buffer holds 2, wr_cnt=16.
REQ-041 With near_full=1 in IDLE and packet start 0xA5 pending -> winc=0 until near_full=0, then wdata=0xA5.
REQ-042 Mid-packet (3 of 5 beats written), near_full=1, full=0 -> beats 4 and 5 written, then state=IDLE.
REQ-043 flush_req pulse with 2 beats buffered in PKT -> next cycle wptr_clr=1, the cycle after flush_ack=1, no further winc, counters=0, state=IDLE.
REQ-044 Three over_flow pulses injected -> ovf_cnt=3; 300 pulses -> ovf_cnt=255.
REQ-045 wrst_n asserted mid-packet -> all outputs at reset values immediately, s_ready=1 one edge after release, the old beats are never written.
